// File: rtl/tlul_reg_host_arb.sv
// tlul_reg_host_arb: round-robin arbiter letting NumHosts TL-UL hosts share one
// single-outstanding TL-UL register device port.
package tlul_pkg;
  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;
  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;
endpackage

module tlul_reg_host_arb
  import tlul_pkg::*;
#(
  parameter int NumHosts = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  tl_h2d_t             tl_h_i [NumHosts],
  output tl_d2h_t             tl_h_o [NumHosts],
  output tl_h2d_t             tl_d_o,
  input  tl_d2h_t             tl_d_i,
  output logic [NumHosts-1:0] gnt_o,
  output logic                busy_o
);
  localparam int HW = (NumHosts > 1) ? $clog2(NumHosts) : 1;
  typedef enum logic [1:0] {IDLE, REQ, RSP} state_e;
  state_e state_q, state_d;
  logic [HW-1:0] prio_q, owner_q, winner, gnt_idx;
  logic any_req, gnt_vld, a_ack, d_ack;
  // search downward so the host closest to prio_q is the last (winning) hit
  always_comb begin
    winner = prio_q;
    any_req = 1'b0;
    for (int k = NumHosts - 1; k >= 0; k--) begin
      if (tl_h_i[(int'(prio_q) + k) % NumHosts].a_valid) begin
        winner = HW'((int'(prio_q) + k) % NumHosts);
        any_req = 1'b1;
      end
    end
  end
  // the owner keeps the grant through REQ and RSP; reset forces the idle view at once
  assign gnt_vld = !rst_i && (state_q != IDLE || any_req);
  assign gnt_idx = (state_q == IDLE) ? winner : owner_q;
  assign gnt_o = gnt_vld ? NumHosts'(1) << gnt_idx : '0;
  assign busy_o = state_q != IDLE;
  always_comb begin
    tl_d_o = gnt_vld ? tl_h_i[gnt_idx] : '0;
    if (state_q == RSP) tl_d_o.a_valid = 1'b0;
  end
  assign a_ack = tl_d_o.a_valid & tl_d_i.a_ready;
  assign d_ack = (state_q == RSP) & tl_d_i.d_valid & tl_h_i[owner_q].d_ready;
  always_comb begin
    state_d = (state_q == IDLE) ? (any_req ? (a_ack ? RSP : REQ) : IDLE) :
              (state_q == REQ)  ? (a_ack ? RSP : (tl_h_i[owner_q].a_valid ? REQ : IDLE)) :
                                  (d_ack ? IDLE : RSP);
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      prio_q  <= '0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && any_req) owner_q <= winner;
      if (a_ack) prio_q <= HW'((int'(gnt_idx) + 1) % NumHosts);
    end
  end
  always_comb begin
    for (int i = 0; i < NumHosts; i++) begin
      tl_h_o[i] = tl_d_i;
      tl_h_o[i].d_valid = tl_d_i.d_valid & (state_q == RSP) & (owner_q == HW'(i));
      tl_h_o[i].a_ready = tl_d_i.a_ready & gnt_o[i] & (state_q != RSP);
    end
  end
  a_req_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (state_q == REQ) |-> tl_h_i[owner_q].a_valid);
  d_only_in_rsp: assert property (@(posedge clk_i) disable iff (rst_i)
    tl_d_i.d_valid |-> (state_q == RSP));
endmodule

// File: tb/tb_tlul_reg_host_arb.sv
// tb_tlul_reg_host_arb: directed checks of the 3-host register arbiter.
module tb_tlul_reg_host_arb;
  import tlul_pkg::*;
  logic clk, rst;
  tl_h2d_t h_in [3];
  tl_d2h_t h_out [3];
  tl_h2d_t d_out;
  tl_d2h_t d_in;
  logic [2:0] gnt;
  logic busy;
  int checks = 0, failures = 0;

  tlul_reg_host_arb #(.NumHosts(3)) dut (
    .clk_i(clk), .rst_i(rst), .tl_h_i(h_in), .tl_h_o(h_out),
    .tl_d_o(d_out), .tl_d_i(d_in), .gnt_o(gnt), .busy_o(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) h_in[i] = '0;
    d_in = '0;
    step;
    step;
    check("rst_gnt", gnt, 0);
    check("rst_busy", busy, 0);
    check("rst_dout", d_out, 0);
    check("rst_ar0", h_out[0].a_ready, 0);
    check("rst_dv0", h_out[0].d_valid, 0);
    check("rst_prio", dut.prio_q, 0);
    check("rst_owner", dut.owner_q, 0);
    rst = 1'b0;
    step;
    // single read from host 0
    h_in[0].a_valid = 1'b1;
    h_in[0].a_opcode = 3'd4;
    h_in[0].a_address = 32'h10;
    h_in[0].a_mask = 4'hf;
    h_in[0].d_ready = 1'b1;
    d_in.a_ready = 1'b1;
    #1;
    check("rd_gnt", gnt, 3'b001);
    check("rd_ar0", h_out[0].a_ready, 1);
    check("rd_ar1", h_out[1].a_ready, 0);
    check("rd_addr", d_out.a_address, 32'h10);
    check("rd_aval", d_out.a_valid, 1);
    check("rd_busy0", busy, 0);
    step;
    h_in[0].a_valid = 1'b0;
    d_in.d_valid = 1'b1;
    d_in.d_data = 32'hDEADBEEF;
    #1;
    check("rd_dv0", h_out[0].d_valid, 1);
    check("rd_data", h_out[0].d_data, 32'hDEADBEEF);
    check("rd_dv1", h_out[1].d_valid, 0);
    check("rd_busy1", busy, 1);
    check("rd_ar0_rsp", h_out[0].a_ready, 0);
    step;
    d_in.d_valid = 1'b0;
    #1;
    check("rd_busy2", busy, 0);
    check("rd_prio", dut.prio_q, 1);
    // backpressure lock: host 1 keeps the grant while host 0 joins
    h_in[1].a_valid = 1'b1;
    h_in[1].a_address = 32'h20;
    d_in.a_ready = 1'b0;
    #1;
    check("bp_gnt_c0", gnt, 3'b010);
    step;
    check("bp_gnt_c1", gnt, 3'b010);
    check("bp_busy", busy, 1);
    step;
    h_in[0].a_valid = 1'b1;
    #1;
    check("bp_gnt_c2", gnt, 3'b010);
    check("bp_ar0", h_out[0].a_ready, 0);
    check("bp_addr", d_out.a_address, 32'h20);
    step;
    check("bp_gnt_c3", gnt, 3'b010);
    step;
    d_in.a_ready = 1'b1;
    #1;
    check("bp_gnt_ack", gnt, 3'b010);
    check("bp_ar1", h_out[1].a_ready, 1);
    step;
    h_in[1].a_valid = 1'b0;
    h_in[1].d_ready = 1'b1;
    d_in.d_valid = 1'b1;
    #1;
    check("bp_dv1", h_out[1].d_valid, 1);
    check("bp_dv0", h_out[0].d_valid, 0);
    check("bp_ar0_rsp", h_out[0].a_ready, 0);
    check("bp_aval_rsp", d_out.a_valid, 0);
    step;
    d_in.d_valid = 1'b0;
    #1;
    check("bp_gnt_h0", gnt, 3'b001);
    check("bp_ar0_ack", h_out[0].a_ready, 1);
    step;
    // D-channel stall by owner 0 while hosts 1 and 2 wait
    h_in[0].a_valid = 1'b0;
    h_in[0].d_ready = 1'b0;
    h_in[1].a_valid = 1'b1;
    h_in[2].a_valid = 1'b1;
    d_in.d_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("st_busy", busy, 1);
      check("st_dready", d_out.d_ready, 0);
      check("st_ar1", h_out[1].a_ready, 0);
      check("st_ar2", h_out[2].a_ready, 0);
      check("st_dv0", h_out[0].d_valid, 1);
      step;
    end
    h_in[0].d_ready = 1'b1;
    #1;
    check("st_dready_rel", d_out.d_ready, 1);
    step;
    d_in.d_valid = 1'b0;
    #1;
    check("st_next_gnt", gnt, 3'b010);
    step;
    h_in[1].a_valid = 1'b0;
    d_in.d_valid = 1'b1;
    step;
    d_in.d_valid = 1'b0;
    #1;
    check("st_gnt_h2", gnt, 3'b100);
    step;
    // reset in the middle of host 2's response
    h_in[2].a_valid = 1'b0;
    h_in[2].d_ready = 1'b0;
    d_in.d_valid = 1'b1;
    #1;
    check("mr_busy_pre", busy, 1);
    check("mr_dv2_pre", h_out[2].d_valid, 1);
    check("mr_prio_wrap", dut.prio_q, 0);
    #1;
    rst = 1'b1;
    #1;
    check("mr_busy", busy, 0);
    check("mr_gnt", gnt, 0);
    check("mr_dout", d_out, 0);
    check("mr_dv2", h_out[2].d_valid, 0);
    check("mr_ar0", h_out[0].a_ready, 0);
    check("mr_prio", dut.prio_q, 0);
    check("mr_owner", dut.owner_q, 0);
    d_in.d_valid = 1'b0;
    step;
    rst = 1'b0;
    // contention: all hosts request continuously, strict rotation from host 0
    for (int i = 0; i < 3; i++) begin
      h_in[i].a_valid = 1'b1;
      h_in[i].d_ready = 1'b1;
    end
    d_in.a_ready = 1'b1;
    for (int t = 0; t < 5; t++) begin
      #1;
      check("ct_gnt", gnt, 3'b001 << (t % 3));
      step;
      d_in.d_valid = 1'b1;
      #1;
      check("ct_dv", h_out[t % 3].d_valid, 1);
      check("ct_dv_other", h_out[(t + 1) % 3].d_valid, 0);
      step;
      d_in.d_valid = 1'b0;
    end
    // wrap-around: prio_q = 2, hosts 0 and 2 requesting
    h_in[1].a_valid = 1'b0;
    #1;
    check("wr_prio2", dut.prio_q, 2);
    check("wr_gnt_h2", gnt, 3'b100);
    step;
    check("wr_prio0", dut.prio_q, 0);
    d_in.d_valid = 1'b1;
    step;
    d_in.d_valid = 1'b0;
    #1;
    check("wr_gnt_h0", gnt, 3'b001);
    step;
    h_in[0].a_valid = 1'b0;
    h_in[2].a_valid = 1'b0;
    d_in.d_valid = 1'b1;
    step;
    d_in.d_valid = 1'b0;
    #1;
    check("wr_idle", busy, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
